// File: rtl/ram_port_arb.sv
// Registered two-requester arbiter for the shared RAM port A. Requester 1 has priority,
// requester 0 is forced through after MAX_WAIT stalls, and lock holds requester 0 off.
module ram_port_arb #(
  parameter int XLEN         = 32,
  parameter int RAM_ADDR_LEN = 14,
  parameter int MAX_WAIT     = 4
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    lock,
  input  logic                    r0_req,
  input  logic [XLEN/8-1:0]       r0_we,
  input  logic [RAM_ADDR_LEN-1:0] r0_addr,
  input  logic [XLEN-1:0]         r0_wdata,
  output logic                    r0_gnt,
  output logic                    r0_rvalid,
  output logic [XLEN-1:0]         r0_rdata,
  input  logic                    r1_req,
  input  logic [XLEN/8-1:0]       r1_we,
  input  logic [RAM_ADDR_LEN-1:0] r1_addr,
  input  logic [XLEN-1:0]         r1_wdata,
  output logic                    r1_gnt,
  output logic                    r1_rvalid,
  output logic [XLEN-1:0]         r1_rdata,
  output logic                    ram_en,
  output logic [XLEN/8-1:0]       ram_we,
  output logic [RAM_ADDR_LEN-1:0] ram_addr,
  output logic [XLEN-1:0]         ram_wdata,
  input  logic [XLEN-1:0]         ram_rdata,
  output logic [15:0]             stall_cnt
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       force0;
  logic       any_gnt;
  logic       gnt_is_read;
  logic       tag1_v, tag1_id;
  logic       tag2_v, tag2_id;

  assign force0  = (wait_cnt == WAIT_MAX) & r0_req & ~lock;
  assign r1_gnt  = r1_req & ~force0;
  assign r0_gnt  = r0_req & ~lock & (force0 | ~r1_req);
  assign any_gnt = r0_gnt | r1_gnt;
  assign gnt_is_read = r1_gnt ? (r1_we == '0) : (r0_we == '0);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ram_en    <= 1'b0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en <= any_gnt;
      if (r1_gnt) begin
        ram_we    <= r1_we;
        ram_addr  <= r1_addr;
        ram_wdata <= r1_wdata;
      end else if (r0_gnt) begin
        ram_we    <= r0_we;
        ram_addr  <= r0_addr;
        ram_wdata <= r0_wdata;
      end else begin
        ram_we <= '0;
      end
    end
  end

  // Read tags follow the access through issue and RAM latency; lock never flushes them.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tag1_v  <= 1'b0;
      tag1_id <= 1'b0;
      tag2_v  <= 1'b0;
      tag2_id <= 1'b0;
    end else begin
      tag1_v  <= any_gnt & gnt_is_read;
      tag1_id <= r1_gnt;
      tag2_v  <= tag1_v;
      tag2_id <= tag1_id;
    end
  end

  assign r0_rvalid = tag2_v & ~tag2_id;
  assign r1_rvalid = tag2_v & tag2_id;
  assign r0_rdata  = r0_rvalid ? ram_rdata : '0;
  assign r1_rdata  = r1_rvalid ? ram_rdata : '0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wait_cnt <= '0;
    end else if (r0_gnt || !r0_req || lock) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Counts locked stalls too, so upgrade time shows up in the performance readout.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stall_cnt <= '0;
    end else if (r0_req && !r0_gnt && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ram_port_arb.sv
// Bench for ram_port_arb: behavioural sync RAM, scoreboard of issues and read returns,
// plus directed checks for contention, lock, byte writes and reset mid-read.
module tb_ram_port_arb;

  logic        clk = 1'b0;
  logic        rstb;
  logic        lock;
  logic        r0_req, r1_req;
  logic [3:0]  r0_we, r1_we;
  logic [13:0] r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [15:0] stall_cnt;

  ram_port_arb dut (
    .clk(clk), .rstb(rstb), .lock(lock),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [13:0] a);
    return 32'h5A00_0000 ^ ({18'd0, a} * 32'h0001_0003);
  endfunction

  logic [31:0] mem     [16384];
  logic [31:0] ref_mem [16384];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } rd_t;

  typedef struct {
    logic [3:0]  we;
    logic [13:0] addr;
    logic [31:0] wdata;
    int          due;
  } iss_t;

  rd_t  rd_q[$];
  iss_t iss_q[$];

  task automatic note_grant(input logic id, input logic [3:0] we, input logic [13:0] addr,
                            input logic [31:0] wdata);
    iss_t i;
    rd_t  r;
    i.we = we; i.addr = addr; i.wdata = wdata; i.due = cyc + 1;
    iss_q.push_back(i);
    if (we == 4'd0) begin
      r.id = id; r.data = ref_mem[addr]; r.due = cyc + 2;
      rd_q.push_back(r);
    end else begin
      for (int b = 0; b < 4; b++)
        if (we[b]) ref_mem[addr][b*8 +: 8] = wdata[b*8 +: 8];
    end
  endtask

  // Scoreboard monitor: expectations pushed at grant, popped at issue / read return.
  always @(negedge clk) begin
    iss_t e;
    rd_t  r;
    if (!rstb) begin
      rd_q.delete();
      iss_q.delete();
    end else begin
      if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
        e = iss_q.pop_front();
        chk("iss_en", 32'(ram_en), 32'd1);
        chk("iss_we", 32'(ram_we), 32'(e.we));
        chk("iss_addr", 32'(ram_addr), 32'(e.addr));
        chk("iss_wdata", ram_wdata, e.wdata);
      end else if (ram_en || ram_we != 4'd0) begin
        chk("iss_idle", {27'd0, ram_we, ram_en}, 32'd0);
      end
      if (r0_rvalid || r1_rvalid) begin
        if (rd_q.size() == 0) begin
          chk("rv_unexp", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
        end else begin
          r = rd_q.pop_front();
          chk("rv_due", 32'(cyc), 32'(r.due));
          chk("rv_id", {30'd0, r1_rvalid, r0_rvalid}, r.id ? 32'd2 : 32'd1);
          chk("rv_data", r.id ? r1_rdata : r0_rdata, r.data);
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r = rd_q.pop_front();
        chk("rv_missing", 32'd0, 32'd1);
      end
      if (!r0_rvalid && r0_rdata != 32'd0) chk("r0_rdata_gate", r0_rdata, 32'd0);
      if (!r1_rvalid && r1_rdata != 32'd0) chk("r1_rdata_gate", r1_rdata, 32'd0);
      if (r0_gnt && r1_gnt) chk("two_gnt", 32'd1, 32'd0);
      if (r1_gnt) note_grant(1'b1, r1_we, r1_addr, r1_wdata);
      else if (r0_gnt) note_grant(1'b0, r0_we, r0_addr, r0_wdata);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  initial begin
    logic g0, g1;
    int   n;
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = init_word(14'(i));
      ref_mem[i] = init_word(14'(i));
    end
    ram_rdata = 32'h0;
    rstb = 0; lock = 0;
    idle_inputs();
    #12;
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_rvalid", {30'd0, r1_rvalid, r0_rvalid}, 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    tick; tick;
    rstb = 1;
    tick;

    // single r0 read
    r0_req = 1; r0_addr = 14'h0010;
    @(negedge clk);
    chk("rd_r0_gnt", 32'(r0_gnt), 32'd1);
    tick;
    r0_req = 0;
    @(negedge clk);
    chk("rd_ram_en", 32'(ram_en), 32'd1);
    chk("rd_ram_addr", 32'(ram_addr), 32'h10);
    tick;
    @(negedge clk);
    chk("rd_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rd_rdata", r0_rdata, init_word(14'h0010));
    chk("rd_r1_rvalid", 32'(r1_rvalid), 32'd0);
    tick; tick;

    // contention: r1 streams writes, r0 forced through after MAX_WAIT stalls
    r1_req = 1; r1_we = 4'hF; r1_addr = 14'h0100; r1_wdata = $urandom;
    r0_req = 1; r0_addr = 14'h0020;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("cont_r1_gnt", 32'(r1_gnt), 32'(i != 4));
      chk("cont_r0_gnt", 32'(r0_gnt), 32'(i == 4));
      g1 = r1_gnt; g0 = r0_gnt;
      tick;
      if (g1) begin r1_addr = r1_addr + 14'd1; r1_wdata = $urandom; end
      if (g0) r0_req = 0;
    end
    r1_req = 0; r1_we = 0;
    @(negedge clk);
    chk("cont_stall", 32'(stall_cnt), 32'd4);
    tick; tick; tick;

    // lock holds r0 off for 100 cycles, then it wins immediately
    lock = 1; r0_req = 1; r0_addr = 14'h0040;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (r0_gnt) n++;
      tick;
    end
    chk("lock_gnts", 32'(n), 32'd0);
    lock = 0;
    @(negedge clk);
    chk("lock_stall", 32'(stall_cnt), 32'd104);
    chk("unlock_gnt", 32'(r0_gnt), 32'd1);
    tick;
    r0_req = 0;
    @(negedge clk);
    chk("unlock_stall", 32'(stall_cnt), 32'd104);
    tick; tick; tick;

    // interleaved reads, one requester per cycle
    for (int i = 0; i < 8; i++) begin
      r0_req = (i % 2 == 0); r0_addr = 14'h0001;
      r1_req = (i % 2 == 1); r1_addr = 14'h0002;
      @(negedge clk);
      chk("ilv_gnt", {30'd0, r1_gnt, r0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick;
    end
    // simultaneous request: r1 first, r0 next cycle
    r0_req = 1; r0_addr = 14'h0003; r1_req = 1; r1_addr = 14'h0004;
    @(negedge clk);
    chk("both_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd2);
    tick;
    r1_req = 0;
    @(negedge clk);
    chk("both_gnt2", {30'd0, r1_gnt, r0_gnt}, 32'd1);
    tick;
    idle_inputs();
    tick; tick; tick;

    // byte write then read back
    r0_req = 1; r0_we = 4'b0010; r0_addr = 14'h0030; r0_wdata = 32'h0000_AB00;
    @(negedge clk);
    chk("bw_gnt", 32'(r0_gnt), 32'd1);
    tick;
    r0_we = 4'b0000; r0_wdata = 32'h0;
    @(negedge clk);
    chk("bw_ram_we", 32'(ram_we), 32'h2);
    chk("bw_rd_gnt", 32'(r0_gnt), 32'd1);
    tick;
    r0_req = 0;
    tick;
    @(negedge clk);
    chk("bw_rvalid", 32'(r0_rvalid), 32'd1);
    chk("bw_rdata", r0_rdata, (init_word(14'h0030) & ~32'h0000_FF00) | 32'h0000_AB00);
    tick; tick;

    // reset in the middle of a read
    r0_req = 1; r0_addr = 14'h0050;
    @(negedge clk);
    chk("rr_gnt", 32'(r0_gnt), 32'd1);
    tick;
    rstb = 0; r0_req = 0;
    #1;
    chk("rr_ram_en", 32'(ram_en), 32'd0);
    chk("rr_ram_addr", 32'(ram_addr), 32'd0);
    chk("rr_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rr_stall", 32'(stall_cnt), 32'd0);
    tick; tick;
    rstb = 1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (r0_rvalid || r1_rvalid) n++;
      tick;
    end
    chk("rr_no_rvalid", 32'(n), 32'd0);

    chk("sb_rd_left", 32'(rd_q.size()), 32'd0);
    chk("sb_iss_left", 32'(iss_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arb.md
Name: ram_port_arb

Overview:
- Arbitrates the single shared data port (port A) of the SDP RAM between two requesters.
  - Requester 0: the core data path, on the RAM side of the data mux.
  - Requester 1: the UART upgrade/loader engine.
- Replaces the combinational upgrade-wins mux in front of port A with a registered, handshaked arbiter.
- Provides bounded-latency starvation protection, a hard lock during software upgrade, and a saturating stall counter for performance readout.

Parameters:
- XLEN, 32, data width; byte-enable width is XLEN/8.
- RAM_ADDR_LEN, 14, RAM word-address width.
- MAX_WAIT, 4, consecutive stalled cycles after which requester 0 is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- lock  in  1  high = requester 0 never granted (tie to during_sw_upgrade)
- r0_req  in  1  requester 0 access request
- r0_we  in  XLEN/8  requester 0 byte write enables; all-zero = read
- r0_addr  in  RAM_ADDR_LEN  requester 0 word address
- r0_wdata  in  XLEN  requester 0 write data
- r0_gnt  out  1  requester 0 request accepted this cycle
- r0_rvalid  out  1  requester 0 read data valid
- r0_rdata  out  XLEN  requester 0 read data
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same widths and meanings, for requester 1
- ram_en  out  1  RAM port A enable
- ram_we  out  XLEN/8  RAM port A byte write enables
- ram_addr  out  RAM_ADDR_LEN  RAM port A address
- ram_wdata  out  XLEN  RAM port A write data
- ram_rdata  in  XLEN  RAM port A read data; synchronous RAM, 1-cycle latency
- stall_cnt  out  16  saturating count of cycles with r0_req high and r0_gnt low

Behaviour:
- Reset: all outputs 0; wait counter 0; pipeline tags cleared. Asynchronous assert, synchronous deassert is supplied externally.
- Grant (combinational, cycle N):
  - Default: requester 1 has priority.
  - r1_gnt = r1_req & ~force0.
  - r0_gnt = r0_req & ~lock & (force0 | ~r1_req).
  - force0 = (wait_cnt == MAX_WAIT) & r0_req & ~lock.
  - At most one grant per cycle. A request is consumed only on its gnt; the requester holds req/we/addr/wdata stable until gnt.
- Issue (cycle N+1):
  - ram_en, ram_we, ram_addr and ram_wdata are registered from the winner.
  - ram_en = 1 and ram_we = winner's we; when there is no grant, ram_en = 0 and ram_we = 0.
- Read return (cycle N+2):
  - A granted read (we == 0) sets a 2-stage tag pipeline {valid, id}.
  - At N+2, rX_rvalid pulses for exactly one cycle for the owning requester.
  - rX_rdata = ram_rdata, gated to 0 when rX_rvalid is 0.
  - Writes produce no rvalid.
- Throughput: one grant per cycle sustained; back-to-back reads from alternating requesters each return in order with correct id.
- Wait counter:
  - Increments when r0_req & ~r0_gnt & ~lock.
  - Clears on r0_gnt, on ~r0_req, or while lock.
  - Saturates at MAX_WAIT.
- Worst-case requester 0 latency with lock low: MAX_WAIT+1 cycles from req to gnt.
- stall_cnt:
  - Increments on r0_req & ~r0_gnt, including while locked.
  - Saturates at 16'hFFFF; never wraps.
  - Cleared only by reset.
- Lock rising while a requester 0 read is in the tag pipeline: the read still completes and returns its rvalid. Lock only blocks new grants.
- Simultaneous requests with force0 = 1: requester 0 wins; requester 1 is held (r1_gnt = 0) for that one cycle only.
- Reset mid-operation: pending tags are discarded; no rvalid is emitted after reset release for pre-reset requests.

Test Plan:
- Single read, r0 only: r0_req=1, addr=0x0010, we=0 at N → r0_gnt=1 at N; ram_en=1, ram_addr=0x0010 at N+1; r0_rvalid=1 with r0_rdata=RAM[0x10] at N+2; r1_rvalid stays 0.
- Contention: r1 writes continuously (we=4'hF) while r0_req is held, MAX_WAIT=4 → r1_gnt for 4 cycles; r0_gnt in cycle 5; r1 resumes in cycle 6; stall_cnt=4.
- Lock: lock=1, r0_req held 100 cycles, r1 idle → r0_gnt never asserted; stall_cnt=100. After lock drops → r0_gnt next cycle.
- Interleaved reads: alternate r0 and r1 reads to 0x0001 and 0x0002 every cycle → each rvalid lands on the correct requester 2 cycles after its grant, with the matching data.
- Byte write: r0 write with we=4'b0010, wdata=0x0000AB00 → ram_we=4'b0010 at N+1; a subsequent read returns only byte 1 changed.
- Reset mid-read: rstb low at N+1 of an r0 read → all outputs 0 immediately; no r0_rvalid after release.
